mem_seg: RTL and testbench

MEM_SEG -- requirements
Module: mem_seg

---
 rtl/mem_seg_if.sv | 40 ++++
 rtl/mem_seg.sv | 110 +++++++++++
 tb/tb_mem_seg.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_seg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seg_if
//  Description : EX/MEM -> MEM/WB pipeline bus for the memory stage.
//                master : upstream side (drives the *_i fields, observes *_o)
//                slave  : mem_seg   (consumes the *_i fields, drives *_o)
//  Signals     : valid_i, IR_i, ALUo_i, B_i, cond_i           (to stage)
//                LMD_o, ALUo_o, IR_o, cond_o, valid_o,         (from stage)
//                br_taken_o, br_target_o, mis_err_o
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_seg_if;
   logic        valid_i;
   logic [31:0] IR_i;
   logic [31:0] ALUo_i;
   logic [31:0] B_i;
   logic [31:0] cond_i;

   logic [31:0] LMD_o;
   logic [31:0] ALUo_o;
   logic [31:0] IR_o;
   logic [31:0] cond_o;
   logic        valid_o;
   logic        br_taken_o;
   logic [31:0] br_target_o;
   logic        mis_err_o;

   modport master (
      output valid_i, IR_i, ALUo_i, B_i, cond_i,
      input  LMD_o, ALUo_o, IR_o, cond_o, valid_o,
      input  br_taken_o, br_target_o, mis_err_o
   );

   modport slave (
      input  valid_i, IR_i, ALUo_i, B_i, cond_i,
      output LMD_o, ALUo_o, IR_o, cond_o, valid_o,
      output br_taken_o, br_target_o, mis_err_o
   );
endinterface
`default_nettype wire

// File: rtl/mem_seg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seg
//  Description : MEM stage of a 5-stage pipeline. Decodes lw/sw/beq, accesses
//                a DEPTH x 32 data memory, registers MEM/WB values and drives
//                the combinational branch redirect.
//  Ports       : clk  - single clock, rising edge
//                rst  - asynchronous active-low reset
//                bus  - mem_seg_if.slave (EX/MEM inputs, MEM/WB outputs,
//                       branch redirect, sticky misalignment flag)
//  Parameters  : DEPTH - memory words (power of two, 4..1024)
//                AW    - word-address width, log2(DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_seg #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic      clk,
   input  logic      rst,
   mem_seg_if.slave  bus
);

   localparam logic [5:0] c_OP_LW  = 6'b100011;
   localparam logic [5:0] c_OP_SW  = 6'b101011;
   localparam logic [5:0] c_OP_BEQ = 6'b000100;

   // ---------------------------------------------------------------- decode
   logic [5:0]    w_op;
   logic          w_is_lw;
   logic          w_is_sw;
   logic          w_is_beq;
   logic          w_misaligned;
   logic          w_valid_eff;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_rdata;

   assign w_op         = bus.IR_i[31:26];
   assign w_is_lw      = (w_op == c_OP_LW);
   assign w_is_sw      = (w_op == c_OP_SW);
   assign w_is_beq     = (w_op == c_OP_BEQ);
   assign w_misaligned = (w_is_lw || w_is_sw) && (bus.ALUo_i[1:0] != 2'b00);
   assign w_valid_eff  = bus.valid_i && !w_misaligned;
   assign w_we         = w_valid_eff && w_is_sw;
   // Upper address bits are dropped, so byte addresses wrap modulo DEPTH*4.
   assign w_addr       = bus.ALUo_i[AW+1:2];

   // ---------------------------------------------------------------- memory
   logic [31:0] mem_q [DEPTH];

   // Not reset; writes are gated by rst so a store caught by a reset assertion
   // before its edge is dropped.
   always_ff @(posedge clk) begin
      if (rst && w_we) begin
         mem_q[w_addr] <= bus.B_i;
      end
   end

   // A lw and a sw never share a cycle, so the combinational read already
   // sees any store committed at the previous edge (write-first behaviour).
   assign w_rdata = mem_q[w_addr];

   // ------------------------------------------------------ MEM/WB registers
   logic [31:0] lmd_q,  lmd_d;
   logic [31:0] aluo_q, aluo_d;
   logic [31:0] ir_q,   ir_d;
   logic [31:0] cond_q, cond_d;
   logic        valid_q, valid_d;
   logic        mis_err_q, mis_err_d;

   always_comb begin
      lmd_d     = (w_valid_eff && w_is_lw) ? w_rdata : 32'h0;
      aluo_d    = bus.ALUo_i;
      cond_d    = bus.cond_i;
      ir_d      = w_valid_eff ? bus.IR_i : 32'h0;
      valid_d   = w_valid_eff;
      mis_err_d = mis_err_q || (bus.valid_i && w_misaligned);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lmd_q     <= 32'h0;
         aluo_q    <= 32'h0;
         ir_q      <= 32'h0;
         cond_q    <= 32'h0;
         valid_q   <= 1'b0;
         mis_err_q <= 1'b0;
      end else begin
         lmd_q     <= lmd_d;
         aluo_q    <= aluo_d;
         ir_q      <= ir_d;
         cond_q    <= cond_d;
         valid_q   <= valid_d;
         mis_err_q <= mis_err_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.LMD_o       = lmd_q;
   assign bus.ALUo_o      = aluo_q;
   assign bus.IR_o        = ir_q;
   assign bus.cond_o      = cond_q;
   assign bus.valid_o     = valid_q;
   assign bus.mis_err_o   = mis_err_q;
   assign bus.br_taken_o  = bus.valid_i && w_is_beq && (bus.cond_i != 32'h0);
   assign bus.br_target_o = bus.ALUo_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_seg
//  Description : Self-checking bench for mem_seg: vector table for single-cycle
//                behaviour, directed sequences for misalignment and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_seg;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mem_seg_if bus ();

   mem_seg #(.DEPTH(256), .AW(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] ir;
      logic [31:0] aluo;
      logic [31:0] b;
      logic [31:0] cond;
      logic [31:0] exp_lmd;
      logic [31:0] exp_ir;
      logic        exp_valid;
      logic        exp_br;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] aluo,
                        input logic [31:0] b, input logic [31:0] cond);
      bus.valid_i = v;
      bus.IR_i    = ir;
      bus.ALUo_i  = aluo;
      bus.B_i     = b;
      bus.cond_i  = cond;
   endtask

   // Drive at the falling edge, let it pass through one rising edge, sample 1 after.
   task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] aluo,
                       input logic [31:0] b, input logic [31:0] cond);
      @(negedge clk);
      drive(v, ir, aluo, b, cond);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      //             name          v     IR            ALUo          B             cond   LMD           IR_o          vo    br
      vecs[0] = '{"sw_10",       1'b1, 32'hAC000000, 32'h00000010, 32'hDEADBEEF, 32'h0, 32'h0,        32'hAC000000, 1'b1, 1'b0};
      vecs[1] = '{"lw_10",       1'b1, 32'h8C000000, 32'h00000010, 32'h0,        32'h0, 32'hDEADBEEF, 32'h8C000000, 1'b1, 1'b0};
      vecs[2] = '{"sw_wrap400",  1'b1, 32'hAC000000, 32'h00000400, 32'h12345678, 32'h0, 32'h0,        32'hAC000000, 1'b1, 1'b0};
      vecs[3] = '{"lw_0",        1'b1, 32'h8C000000, 32'h00000000, 32'h0,        32'h0, 32'h12345678, 32'h8C000000, 1'b1, 1'b0};
      vecs[4] = '{"beq_taken",   1'b1, 32'h10000000, 32'h00000040, 32'h0,        32'h1, 32'h0,        32'h10000000, 1'b1, 1'b1};
      vecs[5] = '{"beq_cond0",   1'b1, 32'h10000000, 32'h00000040, 32'h0,        32'h0, 32'h0,        32'h10000000, 1'b1, 1'b0};
      vecs[6] = '{"beq_bubble",  1'b0, 32'h10000000, 32'h00000040, 32'h0,        32'h1, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[7] = '{"rtype",       1'b1, 32'h00000020, 32'd456,      32'h0,        32'h7, 32'h0,        32'h00000020, 1'b1, 1'b0};
      vecs[8] = '{"lw_bubble",   1'b0, 32'h8C000000, 32'h00000010, 32'h0,        32'h0, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[9] = '{"sw_20",       1'b1, 32'hAC000000, 32'h00000020, 32'h11111111, 32'h0, 32'h0,        32'hAC000000, 1'b1, 1'b0};

      // ---------------------------------------------------------- reset state
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      #12;
      chk("rst_LMD",   bus.LMD_o,   32'h0);
      chk("rst_IR",    bus.IR_o,    32'h0);
      chk("rst_ALUo",  bus.ALUo_o,  32'h0);
      chk("rst_valid", {31'h0, bus.valid_o},   32'h0);
      chk("rst_mis",   {31'h0, bus.mis_err_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // ---------------------------------------------------------- vector table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].ir, vecs[i].aluo, vecs[i].b, vecs[i].cond);
         #1;
         chk({vecs[i].name, "_br"},  {31'h0, bus.br_taken_o}, {31'h0, vecs[i].exp_br});
         chk({vecs[i].name, "_tgt"}, bus.br_target_o, vecs[i].aluo);
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_LMD"},   bus.LMD_o,  vecs[i].exp_lmd);
         chk({vecs[i].name, "_IR"},    bus.IR_o,   vecs[i].exp_ir);
         chk({vecs[i].name, "_ALUo"},  bus.ALUo_o, vecs[i].aluo);
         chk({vecs[i].name, "_cond"},  bus.cond_o, vecs[i].cond);
         chk({vecs[i].name, "_valid"}, {31'h0, bus.valid_o}, {31'h0, vecs[i].exp_valid});
         chk({vecs[i].name, "_mis"},   {31'h0, bus.mis_err_o}, 32'h0);
      end

      // ------------------------------------------------ misaligned store
      step(1'b1, 32'hAC000000, 32'h00000012, 32'h00000055, 32'h0);
      chk("mis_sw_IR",    bus.IR_o, 32'h0);
      chk("mis_sw_valid", {31'h0, bus.valid_o},   32'h0);
      chk("mis_sw_err",   {31'h0, bus.mis_err_o}, 32'h1);
      chk("mis_sw_LMD",   bus.LMD_o, 32'h0);
      step(1'b1, 32'h8C000000, 32'h00000010, 32'h0, 32'h0);
      chk("mis_lw10_LMD", bus.LMD_o, 32'hDEADBEEF);
      chk("mis_sticky1",  {31'h0, bus.mis_err_o}, 32'h1);
      // misaligned lw: bubble, LMD forced to zero, flag still held
      step(1'b1, 32'h8C000000, 32'h00000011, 32'h0, 32'h0);
      chk("mis_lw_LMD",   bus.LMD_o, 32'h0);
      chk("mis_lw_IR",    bus.IR_o,  32'h0);
      step(1'b1, 32'h00000020, 32'd99, 32'h0, 32'h0);
      chk("mis_sticky2",  {31'h0, bus.mis_err_o}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mis_cleared",  {31'h0, bus.mis_err_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // memory survives reset
      step(1'b1, 32'h8C000000, 32'h00000010, 32'h0, 32'h0);
      chk("post_rst_lw10", bus.LMD_o, 32'hDEADBEEF);

      // ------------------------------------------------ reset mid-store
      step(1'b1, 32'h00000020, 32'd321, 32'h0, 32'h5);
      chk("pre_abort_ALUo", bus.ALUo_o, 32'd321);
      @(negedge clk);
      drive(1'b1, 32'hAC000000, 32'h00000020, 32'hCAFEF00D, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_ALUo",  bus.ALUo_o, 32'h0);
      chk("abort_IR",    bus.IR_o,   32'h0);
      chk("abort_cond",  bus.cond_o, 32'h0);
      chk("abort_valid", {31'h0, bus.valid_o}, 32'h0);
      @(posedge clk);
      #1;
      chk("abort_hold_IR", bus.IR_o, 32'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b1;
      step(1'b1, 32'h8C000000, 32'h00000020, 32'h0, 32'h0);
      chk("abort_lw20", bus.LMD_o, 32'h11111111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
